cl_cfg_tst_rsp: RTL
===================

// Module: cl_cfg_tst_rsp
// PURPOSE
//  Responder end of the cfg_bus: decodes the 1-clk wr/rd pulses from the OCL slave fan-out into a
//  256B register window and returns a 1-clk ack plus rdata. Holds a one-shot busy timer and access
//  counters. Instantiated once per test slot (e.g. slots 6-12) so every OCL window is live.
// PARAMETERS
//  ACK_DLY  2            clocks from wr/rd pulse to ack; legal range 1..15
//  BLK_ID   32'h0000_0000  value returned by the ID register
// PORTS
//  clk        in   1   core clock; sole clock
//  rst        in   1   reset, asynchronous assert, active-high
//  cfg_addr   in   32  request byte address; only [7:2] decoded
//  cfg_wdata  in   32  write data, valid with cfg_wr
//  cfg_wr     in   1   1-clk write request pulse
//  cfg_rd     in   1   1-clk read request pulse
//  cfg_ack    out  1   1-clk completion pulse
//  cfg_rdata  out  32  read data; valid on cfg_ack and held until next ack
//  busy       out  1   busy timer running
//  done       out  1   sticky busy-timer completion
// BEHAVIOUR
//  Reset: cfg_ack=0, cfg_rdata=0, busy=0, done=0, all registers and counters 0, FSM=IDLE.
//   rst mid-transaction drops the pending request; no ack is issued.
//  FSM:
//   IDLE -> WAIT on cfg_wr|cfg_rd; latch addr/wdata/type.
//   WAIT: down-counter loaded with ACK_DLY-1 -> ACK at 0 (ACK_DLY=1 goes straight to ACK).
//   ACK: cfg_ack=1 one clk -> IDLE.
//  Latency: ack is exactly ACK_DLY clks after the request pulse.
//  Write side effect: applied in the clk after the pulse, i.e. before ack.
//  Read data: captured into cfg_rdata on the edge that raises cfg_ack.
//  Request while not IDLE: ignored; sets sticky STATUS.ovr.
//   cfg_wr and cfg_rd in the same clk: treated as a write; sets ovr.
//  Register map (byte offset):
//   0x00 CTRL  W: [0] start (self-clearing), [1] clr_cnt (self-clearing); reads 0
//   0x04 STAT  RO: [0] busy, [1] done, [2] ovr; a write of any value clears ovr only
//   0x08 LEN   RW [15:0]: busy timer length in clks
//   0x0C WRCNT RO: accepted writes, saturates at 32'hFFFF_FFFF
//   0x10 RDCNT RO: accepted reads, same saturation
//   0x14/0x18/0x1C SCR0..2 RW: 32-bit scratch
//   0x20 ID    RO: BLK_ID
//   all other offsets: reads 32'hdead_beef, writes ignored, still acked and counted
//  Busy timer:
//   - start while !busy: load LEN, clear done.
//   - LEN>0: busy=1 for exactly LEN clks, then busy=0, done=1 in the same clk.
//   - LEN=0: done=1 next clk, busy stays 0.
//   - start while busy: ignored (no reload).
//  clr_cnt: WRCNT and RDCNT read 0 afterwards; the clearing write itself is not counted
//   (clear wins over increment).
// CONFIGURATION
//  CL_CFG_TST_RSP_TSTAMP_EN defined:
//   - 0x24 TSC: free-running 32-bit clk counter, wraps to 0 after 32'hFFFF_FFFF.
//   - 0x28 TSTART: TSC value latched on each accepted start; both RO, reset 0.
//  Not defined: no counters are built; 0x24/0x28 read 32'hdead_beef like unmapped offsets.
// TESTING
//  1. ACK_DLY=2: write SCR1=32'hA5A5_0001 at offset 0x18 then read 0x18
//     -> each ack exactly 2 clks after pulse; rdata=32'hA5A5_0001; WRCNT=1; RDCNT=1 (after its own ack).
//  2. Read 0x40 and read 0x20 (BLK_ID=32'h1234_5678)
//     -> 32'hdead_beef and 32'h1234_5678, both acked.
//  3. LEN=5, write CTRL=1
//     -> busy high 5 clks; done=1 on busy fall; 2nd start mid-busy leaves busy length 5.
//     LEN=0 then start -> done=1 next clk, busy never 1.
//  4. Second rd pulse 1 clk after a wr (ACK_DLY=4)
//     -> single ack, STAT=32'h4 after; write STAT -> ovr clears.
//     wr+rd same clk -> write performed, ovr=1.
//  5. Assert rst 1 clk after a rd pulse -> no ack ever; all outputs 0; next request completes normally.
//  6. With TSTAMP_EN: start at TSC=N -> TSTART reads N+1 (latched clk after pulse).
//     Without TSTAMP_EN: 0x24 reads 32'hdead_beef.

Source files
------------

// File: rtl/cl_cfg_tst_rsp.sv
// cl_cfg_tst_rsp: responder end of the cfg_bus.
// Decodes 1-clk cfg_wr/cfg_rd pulses into a 256-byte register window. It
// answers each accepted request with a 1-clk cfg_ack exactly ACK_DLY clocks
// after the pulse. The block also holds a one-shot busy timer and saturating
// access counters.
// Optional feature: define CL_CFG_TST_RSP_TSTAMP_EN to build the TSC / TSTART
// timestamp registers at offsets 0x24 / 0x28.
//
// Handshake: cfg_wr / cfg_rd are single-cycle request pulses. They are only
// accepted while the FSM is IDLE; a pulse in any other state is dropped and
// sets the sticky STAT.ovr bit. Each accepted request gets exactly one
// cfg_ack pulse. For reads, cfg_rdata is valid with that pulse and holds
// until the next read ack. A write takes effect on the edge that accepts it,
// so the effect is visible before the ack. A pulse with both wr and rd
// high is handled as a write and also sets ovr.
// ACK_DLY must lie in 1..15.

module cl_cfg_tst_rsp #(
    parameter int unsigned ACK_DLY = 2,
    parameter logic [31:0] BLK_ID  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_wr,
    input  logic        cfg_rd,
    output logic        cfg_ack,
    output logic [31:0] cfg_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] DLY_LOAD = 4'(ACK_DLY - 1);
    localparam bit         DLY_ONE  = (ACK_DLY == 1);

    // Word indices (byte offset / 4)
    localparam logic [5:0] IDX_CTRL   = 6'h00;
    localparam logic [5:0] IDX_STAT   = 6'h01;
    localparam logic [5:0] IDX_LEN    = 6'h02;
    localparam logic [5:0] IDX_WRCNT  = 6'h03;
    localparam logic [5:0] IDX_RDCNT  = 6'h04;
    localparam logic [5:0] IDX_SCR0   = 6'h05;
    localparam logic [5:0] IDX_SCR1   = 6'h06;
    localparam logic [5:0] IDX_SCR2   = 6'h07;
    localparam logic [5:0] IDX_ID     = 6'h08;
`ifdef CL_CFG_TST_RSP_TSTAMP_EN
    localparam logic [5:0] IDX_TSC    = 6'h09;
    localparam logic [5:0] IDX_TSTART = 6'h0A;
`endif

    // FSM state, exposed as a plain variable so checkers can bind to it
    state_t      state;
    logic [3:0]  dly_cnt;
    logic        req_rd;
    logic [5:0]  req_idx;

    // Register file
    logic [15:0] len;
    logic [31:0] scr0;
    logic [31:0] scr1;
    logic [31:0] scr2;
    logic        ovr;
    logic [31:0] wrcnt;
    logic [31:0] rdcnt;
    logic [15:0] tmr_cnt;

    // Request decode
    logic        req_any;
    logic        accept;
    logic        acc_wr;
    logic [5:0]  acc_idx;
    logic        ack_fire;
    logic        fire_rd;
    logic        rd_fire;
    logic [5:0]  cap_idx;
    logic        ovr_set;
    logic        start_go;
    logic        clr_go;
    logic [31:0] rd_mux;

    // Only address bits [7:2] select a register
    logic        unused_addr;
    assign unused_addr = ^{cfg_addr[31:8], cfg_addr[1:0]};

    assign req_any  = cfg_wr | cfg_rd;
    assign accept   = (state == ST_IDLE) && req_any;
    assign acc_wr   = accept && cfg_wr;
    assign acc_idx  = cfg_addr[7:2];

    // The edge that raises cfg_ack: the accept edge itself when ACK_DLY=1,
    // otherwise the last WAIT clock.
    assign ack_fire = (accept && DLY_ONE) || ((state == ST_WAIT) && (dly_cnt == 4'd1));
    assign fire_rd  = (state == ST_IDLE) ? !cfg_wr : req_rd;
    assign rd_fire  = ack_fire && fire_rd;
    assign cap_idx  = (state == ST_IDLE) ? acc_idx : req_idx;

    assign ovr_set  = (req_any && (state != ST_IDLE)) ||
                      ((state == ST_IDLE) && cfg_wr && cfg_rd);
    assign start_go = acc_wr && (acc_idx == IDX_CTRL) && cfg_wdata[0] && !busy;
    assign clr_go   = acc_wr && (acc_idx == IDX_CTRL) && cfg_wdata[1];

`ifdef CL_CFG_TST_RSP_TSTAMP_EN
    logic [31:0] tsc;
    logic [31:0] tstart;

    // Free-running timestamp; TSTART records the TSC value of the clock after the start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tsc    <= 32'h0;
            tstart <= 32'h0;
        end else begin
            tsc <= tsc + 32'h1;
            if (start_go) begin
                tstart <= tsc + 32'h1;
            end
        end
    end
`endif

    // Read-data mux for the request currently being acked
    always_comb begin
        rd_mux = 32'hdead_beef;
        case (cap_idx)
            IDX_CTRL:   rd_mux = 32'h0;
            IDX_STAT:   rd_mux = {29'h0, ovr, done, busy};
            IDX_LEN:    rd_mux = {16'h0, len};
            IDX_WRCNT:  rd_mux = wrcnt;
            IDX_RDCNT:  rd_mux = rdcnt;
            IDX_SCR0:   rd_mux = scr0;
            IDX_SCR1:   rd_mux = scr1;
            IDX_SCR2:   rd_mux = scr2;
            IDX_ID:     rd_mux = BLK_ID;
`ifdef CL_CFG_TST_RSP_TSTAMP_EN
            IDX_TSC:    rd_mux = tsc;
            IDX_TSTART: rd_mux = tstart;
`endif
            default:    rd_mux = 32'hdead_beef;
        endcase
    end

    // Request FSM: accept in IDLE, count down ACK_DLY, pulse ack for one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dly_cnt   <= 4'h0;
            req_rd    <= 1'b0;
            req_idx   <= 6'h0;
            cfg_ack   <= 1'b0;
            cfg_rdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cfg_ack <= 1'b0;
                    if (req_any) begin
                        req_rd  <= !cfg_wr;
                        req_idx <= acc_idx;
                        dly_cnt <= DLY_LOAD;
                        state   <= DLY_ONE ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    dly_cnt <= dly_cnt - 4'h1;
                    if (dly_cnt == 4'd1) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    cfg_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    cfg_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
            if (ack_fire) begin
                cfg_ack <= 1'b1;
                if (fire_rd) begin
                    cfg_rdata <= rd_mux;
                end
            end
        end
    end

    // Writable registers and the sticky overrun flag (a new overrun beats a STAT write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len  <= 16'h0;
            scr0 <= 32'h0;
            scr1 <= 32'h0;
            scr2 <= 32'h0;
            ovr  <= 1'b0;
        end else begin
            if (acc_wr) begin
                case (acc_idx)
                    IDX_LEN:  len  <= cfg_wdata[15:0];
                    IDX_SCR0: scr0 <= cfg_wdata;
                    IDX_SCR1: scr1 <= cfg_wdata;
                    IDX_SCR2: scr2 <= cfg_wdata;
                    default: ;
                endcase
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (acc_wr && (acc_idx == IDX_STAT)) begin
                ovr <= 1'b0;
            end
        end
    end

    // Saturating access counters; writes count on accept, reads on their ack, clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrcnt <= 32'h0;
            rdcnt <= 32'h0;
        end else if (clr_go) begin
            wrcnt <= 32'h0;
            rdcnt <= 32'h0;
        end else begin
            if (acc_wr && (wrcnt != 32'hFFFF_FFFF)) begin
                wrcnt <= wrcnt + 32'h1;
            end
            if (rd_fire && (rdcnt != 32'hFFFF_FFFF)) begin
                rdcnt <= rdcnt + 32'h1;
            end
        end
    end

    // One-shot busy timer: busy for LEN clocks, done set on the clock busy falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            tmr_cnt <= 16'h0;
        end else if (start_go) begin
            if (len == 16'h0) begin
                done <= 1'b1;
            end else begin
                busy    <= 1'b1;
                done    <= 1'b0;
                tmr_cnt <= len - 16'h1;
            end
        end else if (busy) begin
            if (tmr_cnt == 16'h0) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                tmr_cnt <= tmr_cnt - 16'h1;
            end
        end
    end

endmodule
